// File: rtl/angle_rom_arb_if.sv
// Requester, status and angle-ROM signals of the shared ROM arbiter.
// slave: the arbiter; master: the requesters/ROM side.
interface angle_rom_arb_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        halt_req;
  logic                        halted;
  logic [ADDR_WIDTH-1:0]       rom_addr;
  logic                        rom_clk_en;
  logic                        rom_rd_oce;
  logic [DATA_WIDTH-1:0]       rom_rd_data;

  modport slave (
    input  req, req_addr, halt_req, rom_rd_data,
    output gnt, rd_valid, rd_data, halted, rom_addr, rom_clk_en, rom_rd_oce
  );

  modport master (
    output req, req_addr, halt_req, rom_rd_data,
    input  gnt, rd_valid, rd_data, halted, rom_addr, rom_clk_en, rom_rd_oce
  );
endinterface

// File: rtl/angle_rom_arb.sv
// Round-robin arbiter sharing one angle ROM among N_REQ requesters, with halt/drain control.
// Define ANGLE_ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module angle_rom_arb #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic            clk,
  input logic            rst,
  angle_rom_arb_if.slave bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W-1:0]      cand;
  logic                  sel_any;
  logic                  grant_ok;
  logic                  grant_fire;
  logic [RD_LATENCY-1:0] vld_sr;
  logic [IDX_W-1:0]      idx_sr [RD_LATENCY];
  logic                  pipe_busy;
  logic                  in_flight;
  logic                  out_vld;
  logic [DATA_WIDTH-1:0] data_c;

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_arr[g] = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Grants only in RUN with no halt request; reset forces every output low.
  assign grant_ok   = rst && (state == RUN) && !bus.halt_req;
  assign grant_fire = sel_any && grant_ok;

`ifdef ANGLE_ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    sel_any = |bus.req;
    sel_idx = '0;
    cand    = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      cand = IDX_W'(i);
      if (bus.req[cand]) sel_idx = cand;
    end
  end
`else
  logic [IDX_W-1:0] last_idx;

  // Descending scan so the candidate right after last_idx is assigned last and wins.
  always_comb begin
    sel_any = |bus.req;
    sel_idx = '0;
    cand    = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand = IDX_W'((int'(last_idx) + k) % int'(N_REQ));
      if (bus.req[cand]) sel_idx = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_idx <= IDX_W'(N_REQ - 1);
    end else if (grant_fire) begin
      last_idx <= sel_idx;
    end
  end
`endif

  assign bus.gnt      = grant_fire ? (N_REQ'(1) << sel_idx) : '0;
  assign bus.rom_addr = grant_fire ? addr_arr[sel_idx] : '0;

  // Valid/index shift register tracking reads through the ROM latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_sr <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) idx_sr[i] <= '0;
    end else begin
      vld_sr[0] <= grant_fire;
      idx_sr[0] <= sel_idx;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end
    end
  end

  assign pipe_busy = |vld_sr;

  if (RD_LATENCY > 1) begin : g_oreg
    assign in_flight      = |vld_sr[RD_LATENCY-2:0];
    assign bus.rom_rd_oce = rst && vld_sr[RD_LATENCY-2];
  end else begin : g_noreg
    assign in_flight      = 1'b0;
    assign bus.rom_rd_oce = 1'b0;
  end

  assign bus.rom_clk_en = grant_fire || (rst && in_flight);

  assign out_vld      = rst && vld_sr[RD_LATENCY-1];
  assign data_c       = out_vld ? bus.rom_rd_data : '0;
  assign bus.rd_valid = out_vld ? (N_REQ'(1) << idx_sr[RD_LATENCY-1]) : '0;
  assign bus.rd_data  = data_c;

  // Halt control: drain outstanding reads before reporting halted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (bus.halt_req) state <= DRAIN;
        DRAIN: begin
          if (!bus.halt_req)  state <= RUN;
          else if (!pipe_busy) state <= HALT;
        end
        HALT:    if (!bus.halt_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.halted = rst && (state == HALT);
endmodule

// File: tb/tb_angle_rom_arb.sv
// Directed bench for angle_rom_arb: one instance at RD_LATENCY=1, one at RD_LATENCY=2.
`timescale 1ns/1ps
module tb_angle_rom_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  angle_rom_arb_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  angle_rom_arb_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if2 ();

  angle_rom_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  angle_rom_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  // ROM models: plain synchronous read, and read plus output register.
  logic [31:0] r1_q, r2_q1, r2_q2;
  always @(posedge clk) begin
    if (if1.rom_clk_en) r1_q  <= rom_word(if1.rom_addr);
    if (if2.rom_clk_en) r2_q1 <= rom_word(if2.rom_addr);
    if (if2.rom_rd_oce) r2_q2 <= r2_q1;
  end
  assign if1.rom_rd_data = r1_q;
  assign if2.rom_rd_data = r2_q2;

  localparam logic [3:0] D_REQ [11] = '{4'b0111, 4'b0110, 4'b0100, 4'b0001, 4'b0001, 4'b0001,
                                        4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
  localparam logic       D_HLT [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [3:0] D_GNT [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                                        4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
  localparam logic [3:0] D_VLD [11] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000,
                                        4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
  localparam logic       D_HTD [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic       D_OCE [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    if1.req = '0; if2.req = '0; if1.halt_req = 1'b0; if2.halt_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    if1.req = 4'b1111; if2.req = 4'b1111;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++;
      if ({if1.gnt, if1.rd_valid, if1.rom_clk_en, if1.rom_rd_oce, if1.halted, if1.rd_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_outs_lat1: gnt=%b rd_valid=%b clk_en=%b halted=%b required all 0",
                 if1.gnt, if1.rd_valid, if1.rom_clk_en, if1.halted);
      end
      n_checks++;
      if ({if2.gnt, if2.rd_valid, if2.rom_clk_en, if2.rom_rd_oce, if2.halted, if2.rd_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_outs_lat2: gnt=%b rd_valid=%b clk_en=%b halted=%b required all 0",
                 if2.gnt, if2.rd_valid, if2.rom_clk_en, if2.halted);
      end
    end
    @(negedge clk);
    rst = 1'b1; if1.req = '0; if2.req = '0;
    #1;
    n_checks++;
    if ({if1.gnt, if1.rd_valid, if1.halted, if1.rom_clk_en,
         if2.gnt, if2.rd_valid, if2.halted, if2.rom_clk_en} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle: lat1 vld=%b halted=%b lat2 vld=%b halted=%b required 0",
               if1.rd_valid, if1.halted, if2.rd_valid, if2.halted);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp_d;
    exp_d = rom_word(10'd5);
    @(negedge clk);
    if1.req = 4'b0001; if1.req_addr = {10'd0, 10'd0, 10'd0, 10'd5}; #1;
    n_checks++;
    if (if1.gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b required 0001", if1.gnt); end
    n_checks++;
    if (if1.rom_addr !== 10'd5) begin n_fail++; $display("FAIL single_addr: got %0d required 5", if1.rom_addr); end
    n_checks++;
    if (if1.rom_clk_en !== 1'b1) begin n_fail++; $display("FAIL single_clk_en: got %b required 1", if1.rom_clk_en); end
    @(negedge clk);
    if1.req = '0; #1;
    n_checks++;
    if (if1.rd_valid !== 4'b0001) begin n_fail++; $display("FAIL single_vld: got %b required 0001", if1.rd_valid); end
    n_checks++;
    if (if1.rd_data !== exp_d) begin n_fail++; $display("FAIL single_data: got %h required %h", if1.rd_data, exp_d); end
    n_checks++;
    if (if1.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_no_gnt: got %b required 0000", if1.gnt); end
    @(negedge clk); #1;
    n_checks++;
    if ({if1.rd_valid, if1.rd_data} !== '0) begin
      n_fail++; $display("FAIL single_idle: rd_valid=%b rd_data=%h required 0", if1.rd_valid, if1.rd_data);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g, prev_g;
    logic [9:0] exp_a, prev_a;
    int         idx;
    do_reset();
    if1.req_addr = {10'd400, 10'd300, 10'd200, 10'd100};
    prev_g = '0; prev_a = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if1.req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
`ifdef ANGLE_ROM_ARB_FIXED_PRIO_EN
      idx = 0;
`else
      idx = c % 4;
`endif
      exp_g = (c < 8) ? (4'b0001 << idx) : 4'b0000;
      exp_a = 10'((idx + 1) * 100);
      n_checks++;
      if (if1.gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b required %b", c, if1.gnt, exp_g); end
      if (c < 8) begin
        n_checks++;
        if (if1.rom_addr !== exp_a || if1.rom_clk_en !== 1'b1) begin
          n_fail++; $display("FAIL rr_addr[%0d]: got %0d/en=%b required %0d/en=1", c, if1.rom_addr, if1.rom_clk_en, exp_a);
        end
      end
      if (c > 0) begin
        n_checks++;
        if (if1.rd_valid !== prev_g || if1.rd_data !== rom_word(prev_a)) begin
          n_fail++; $display("FAIL rr_ret[%0d]: got %b/%h required %b/%h", c, if1.rd_valid, if1.rd_data, prev_g, rom_word(prev_a));
        end
      end
      prev_g = exp_g; prev_a = exp_a;
    end
  endtask

  task automatic test_drain();
    logic [3:0]  ev;
    logic [31:0] exp_d;
    if2.req_addr = {10'd400, 10'd300, 10'd200, 10'd100};
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if2.req = D_REQ[c]; if2.halt_req = D_HLT[c];
      #1;
      ev = D_VLD[c];
      exp_d = '0;
      for (int i = 0; i < 4; i++) if (ev[i]) exp_d = rom_word(10'((i + 1) * 100));
      n_checks++;
      if (if2.gnt !== D_GNT[c]) begin n_fail++; $display("FAIL drain_gnt[%0d]: got %b required %b", c, if2.gnt, D_GNT[c]); end
      n_checks++;
      if (if2.rd_valid !== ev) begin n_fail++; $display("FAIL drain_vld[%0d]: got %b required %b", c, if2.rd_valid, ev); end
      n_checks++;
      if (if2.rd_data !== exp_d) begin n_fail++; $display("FAIL drain_data[%0d]: got %h required %h", c, if2.rd_data, exp_d); end
      n_checks++;
      if (if2.halted !== D_HTD[c]) begin n_fail++; $display("FAIL drain_halted[%0d]: got %b required %b", c, if2.halted, D_HTD[c]); end
      n_checks++;
      if (if2.rom_rd_oce !== D_OCE[c]) begin n_fail++; $display("FAIL drain_oce[%0d]: got %b required %b", c, if2.rom_rd_oce, D_OCE[c]); end
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    if1.req = 4'b0100; if2.req = 4'b0100; #1;
    n_checks++;
    if (if1.gnt !== 4'b0100 || if2.gnt !== 4'b0100) begin
      n_fail++; $display("FAIL rst_pre_gnt: got %b/%b required 0100/0100", if1.gnt, if2.gnt);
    end
    @(negedge clk);
    rst = 1'b0; if1.req = '0; if2.req = '0; #1;
    n_checks++;
    if ({if1.rd_valid, if2.rd_valid, if1.rd_data} !== '0) begin
      n_fail++; $display("FAIL rst_in_vld: got %b/%b required 0000/0000", if1.rd_valid, if2.rd_valid);
    end
    @(negedge clk);
    rst = 1'b1; if1.req = 4'b1111; if2.req = 4'b1111; #1;
    n_checks++;
    if (if1.rd_valid !== 4'b0000 || if2.rd_valid !== 4'b0000) begin
      n_fail++; $display("FAIL rst_after_vld: got %b/%b required 0000/0000", if1.rd_valid, if2.rd_valid);
    end
    n_checks++;
    if (if1.gnt !== 4'b0001 || if2.gnt !== 4'b0001) begin
      n_fail++; $display("FAIL rst_first_gnt: got %b/%b required 0001/0001", if1.gnt, if2.gnt);
    end
    @(negedge clk);
    if1.req = '0; if2.req = '0; #1;
    n_checks++;
    if (if1.rd_valid !== 4'b0001 || if2.rd_valid !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ret1: got %b/%b required 0001/0000", if1.rd_valid, if2.rd_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (if1.rd_valid !== 4'b0000 || if2.rd_valid !== 4'b0001) begin
      n_fail++; $display("FAIL rst_ret2: got %b/%b required 0000/0001", if1.rd_valid, if2.rd_valid);
    end
  endtask

  task automatic test_idle();
    int waited;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (if1.rom_clk_en !== 1'b0 || if2.rom_clk_en !== 1'b0) begin
        n_fail++; $display("FAIL idle_clk_en[%0d]: got %b/%b required 0/0", c, if1.rom_clk_en, if2.rom_clk_en);
      end
    end
    @(negedge clk);
    if1.halt_req = 1'b1; if2.halt_req = 1'b1; #1;
    n_checks++;
    if (if1.halted !== 1'b0 || if2.halted !== 1'b0) begin
      n_fail++; $display("FAIL idle_halted_early: got %b/%b required 0/0", if1.halted, if2.halted);
    end
    waited = 0;
    while (!(if1.halted === 1'b1 && if2.halted === 1'b1) && waited < 2) begin
      @(negedge clk); #1;
      waited++;
    end
    n_checks++;
    if (if1.halted !== 1'b1 || if2.halted !== 1'b1) begin
      n_fail++; $display("FAIL idle_halted: got %b/%b after %0d cycles required 1/1", if1.halted, if2.halted, waited);
    end
    @(negedge clk);
    if1.halt_req = 1'b0; if2.halt_req = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (if1.halted !== 1'b0 || if2.halted !== 1'b0) begin
      n_fail++; $display("FAIL idle_resume: got %b/%b required 0/0", if1.halted, if2.halted);
    end
  endtask

  initial begin
    rst = 1'b0;
    if1.req = '0; if1.req_addr = '0; if1.halt_req = 1'b0;
    if2.req = '0; if2.req_addr = '0; if2.halt_req = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_drain();
    test_reset_inflight();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
